// File: rtl/fetch_flow_ctrl.sv
// Fetch-side flow control: owns the PC, issues single-outstanding instruction fetches,
// and holds the IF/ID register with a one-entry skid buffer for responses landing during a stall.
module fetch_flow_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BOOT_CYCLES = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_inst,
    output logic        id_ex_bubble
);

    localparam int CW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CW-1:0] BOOT_LAST = CW'(BOOT_CYCLES - 1);

    typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT, S_DROP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic          skid_valid_q, skid_valid_d;
    logic [31:0]   skid_pc_q, skid_pc_d;
    logic [31:0]   skid_inst_q, skid_inst_d;
    logic          if_id_valid_q, if_id_valid_d;
    logic [31:0]   if_id_pc_q, if_id_pc_d;
    logic [31:0]   if_id_inst_q, if_id_inst_d;
    logic          accept;

    // A full skid buffer throttles fetch so a second response can never arrive with nowhere to go.
    assign im_req       = (state_q == S_REQ) && !redirect && !skid_valid_q;
    assign im_addr      = im_req ? pc_q : 32'h0;
    assign accept       = (state_q == S_WAIT) && im_rvalid && !redirect;
    assign id_ex_bubble = stall | redirect | !if_id_valid_q;

    assign if_id_valid = if_id_valid_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_inst  = if_id_inst_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        skid_valid_d  = skid_valid_q;
        skid_pc_d     = skid_pc_q;
        skid_inst_d   = skid_inst_q;
        if_id_valid_d = if_id_valid_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_inst_d  = if_id_inst_q;

        case (state_q)
            S_BOOT: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == BOOT_LAST) state_d = S_REQ;
            end
            S_REQ:  if (im_req) state_d = S_WAIT;
            S_WAIT: begin
                if (im_rvalid)     state_d = S_REQ;
                else if (redirect) state_d = S_DROP;
            end
            S_DROP: if (im_rvalid) state_d = S_REQ;
            default: state_d = S_BOOT;
        endcase

        if (im_req) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
        end

        if (redirect) begin
            pc_d          = redirect_pc;
            if_id_valid_d = 1'b0;
            skid_valid_d  = 1'b0;
        end else if (!stall) begin
            if (skid_valid_q) begin
                if_id_valid_d = 1'b1;
                if_id_pc_d    = skid_pc_q;
                if_id_inst_d  = skid_inst_q;
                skid_valid_d  = 1'b0;
            end else if (accept) begin
                if_id_valid_d = 1'b1;
                if_id_pc_d    = req_pc_q;
                if_id_inst_d  = im_rdata;
            end else begin
                if_id_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!if_id_valid_q) begin
                if_id_valid_d = 1'b1;
                if_id_pc_d    = req_pc_q;
                if_id_inst_d  = im_rdata;
            end else begin
                skid_valid_d = 1'b1;
                skid_pc_d    = req_pc_q;
                skid_inst_d  = im_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_BOOT;
            cnt_q         <= '0;
            pc_q          <= RESET_PC;
            req_pc_q      <= 32'h0;
            skid_valid_q  <= 1'b0;
            skid_pc_q     <= 32'h0;
            skid_inst_q   <= 32'h0;
            if_id_valid_q <= 1'b0;
            if_id_pc_q    <= 32'h0;
            if_id_inst_q  <= 32'h0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            skid_valid_q  <= skid_valid_d;
            skid_pc_q     <= skid_pc_d;
            skid_inst_q   <= skid_inst_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_inst_q  <= if_id_inst_d;
        end
    end

endmodule
